// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with run control (IDLE/RUN/DONE), match counting,
// overlap selection and abort. Optional cycle timeout enabled by SEQ_DETECT_CTRL_TIMEOUT_EN.
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 4
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  , parameter int TO_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LEN_W-1:0]  pat_len,
  input  logic              overlap,
  input  logic [CNT_W-1:0]  target,
  input  logic              abort,
  input  logic              x,
  input  logic              x_valid,
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  input  logic [TO_W-1:0]   timeout_val,
  output logic              timeout,
`endif
  output logic              busy,
  output logic              z,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [MAXLEN-2:0]   r_hist;
  logic [LEN_W-1:0]    r_fill;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_z;
  logic                r_err;
  logic [MAXLEN-1:0]   r_pat;
  logic [LEN_W-1:0]    r_len;
  logic                r_ovl;
  logic [CNT_W-1:0]    r_tgt;

  logic                w_len_ok;
  logic                w_accept;
  logic                w_sample;
  logic [MAXLEN-1:0]   w_hist_next;
  logic [LEN_W-1:0]    w_fill_next;
  logic                w_match;
  logic                w_tgt_hit;
  logic                w_to_hit;

  // Bit i is set for every pattern position below len.
  function automatic logic [MAXLEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAXLEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      m[i] = (i < int'(len)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  assign w_len_ok    = (pat_len != '0) && (pat_len <= LEN_W'(MAXLEN));
  assign w_accept    = (r_state == IDLE) && start && w_len_ok;
  // abort wins over the sampled bit, so that bit never reaches hist or the counter.
  assign w_sample    = (r_state == RUN) && x_valid && !abort;
  assign w_hist_next = {r_hist, x};
  assign w_fill_next = (r_fill >= LEN_W'(MAXLEN)) ? LEN_W'(MAXLEN) : r_fill + LEN_W'(1);
  assign w_match     = w_sample && (w_fill_next >= r_len) &&
                       (((w_hist_next ^ r_pat) & len_mask(r_len)) == '0);
  assign w_tgt_hit   = w_match && (r_tgt != '0) &&
                       ((CNT_W+1)'(r_cnt) + (CNT_W+1)'(1) == (CNT_W+1)'(r_tgt));

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] r_tcnt;
  logic [TO_W-1:0] r_to_val;
  logic            r_timeout;

  assign w_to_hit = (r_state == RUN) && (r_to_val != '0) && (r_tcnt + TO_W'(1) == r_to_val);
  assign timeout  = r_timeout;

  // RUN-cycle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt    <= '0;
      r_to_val  <= '0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_tcnt    <= '0;
      r_to_val  <= timeout_val;
      r_timeout <= 1'b0;
    end else if (r_state == RUN) begin
      r_tcnt <= r_tcnt + TO_W'(1);
      if (w_to_hit && !abort && !w_tgt_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (abort || w_tgt_hit || w_to_hit) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Config capture, shift history, fill tracking, match counting and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_z    <= 1'b0;
      r_err  <= 1'b0;
      r_pat  <= '0;
      r_len  <= '0;
      r_ovl  <= 1'b0;
      r_tgt  <= '0;
    end else begin
      r_z <= w_match;
      if (r_state == IDLE && start) begin
        if (w_len_ok) begin
          r_pat  <= pattern;
          r_len  <= pat_len;
          r_ovl  <= overlap;
          r_tgt  <= target;
          r_hist <= '0;
          r_fill <= '0;
          r_cnt  <= '0;
          r_err  <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (w_sample) begin
        r_hist <= w_hist_next[MAXLEN-2:0];
        r_fill <= (w_match && !r_ovl) ? LEN_W'(0) : w_fill_next;
        if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign z         = r_z;
  assign match_cnt = r_cnt;
  assign err       = r_err;

endmodule
